// File: rtl/sram_capture_sequencer.sv
// Capture-SRAM sequencer: writes DEPTH bytes from a valid/ready source, then reads them back LSB-first on a serial stream.
// Define SEQ_PARITY_EN to append an even-parity bit after each serialised word.
module sram_capture_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_write,
  input  logic              start_read,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy,
  output logic              write_done,
  output logic              read_done,
  output logic              filled
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] LASTWORD = CW'(DEPTH - 1);
`ifdef SEQ_PARITY_EN
  localparam logic [BW-1:0] LASTBIT = BW'(DATA_W);
`else
  localparam logic [BW-1:0] LASTBIT = BW'(DATA_W - 1);
`endif

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_LOAD, SHIFT} state_t;
  state_t state, nextState;

  logic [CW-1:0]     wordCnt;
  logic [BW-1:0]     bitCnt;
  logic [DATA_W-1:0] shreg;
  logic              accept, wordEnd;
`ifdef SEQ_PARITY_EN
  logic              parity;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_last  = 1'b0;
    accept    = 1'b0;
    wordEnd   = 1'b0;
    case (state)
      IDLE: begin
        if (start_write)     nextState = WR;
        else if (start_read) nextState = RD_ADDR;
      end
      WR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          mem_cs    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(wordCnt);
          mem_wdata = in_data;
          if (wordCnt == LASTWORD) nextState = IDLE;
        end
      end
      RD_ADDR: begin
        mem_cs    = 1'b1;
        mem_oe    = 1'b1;
        mem_addr  = ADDR_W'(wordCnt);
        nextState = RD_LOAD;
      end
      RD_LOAD: nextState = SHIFT;
      SHIFT: begin
        ser_valid = 1'b1;
`ifdef SEQ_PARITY_EN
        ser_bit   = (bitCnt == LASTBIT) ? parity : shreg[0];
`else
        ser_bit   = shreg[0];
`endif
        if (bitCnt == LASTBIT) begin
          wordEnd = 1'b1;
          if (wordCnt == LASTWORD) begin
            ser_last  = 1'b1;
            nextState = IDLE;
          end else begin
            nextState = RD_ADDR;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      wordCnt    <= '0;
      bitCnt     <= '0;
      shreg      <= '0;
      write_done <= 1'b0;
      read_done  <= 1'b0;
      filled     <= 1'b0;
`ifdef SEQ_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      write_done <= accept && (wordCnt == LASTWORD);
      read_done  <= ser_last;
      if (accept && (wordCnt == LASTWORD)) filled <= 1'b1;
      case (state)
        IDLE: begin
          wordCnt <= '0;
          bitCnt  <= '0;
        end
        WR: if (accept && (wordCnt != LASTWORD)) wordCnt <= wordCnt + CW'(1);
        RD_LOAD: begin
          shreg  <= mem_rdata;
          bitCnt <= '0;
`ifdef SEQ_PARITY_EN
          parity <= ^mem_rdata;
`endif
        end
        SHIFT: begin
          shreg  <= shreg >> 1;
          bitCnt <= bitCnt + BW'(1);
          // word count holds at the last word; the IDLE return clears it
          if (wordEnd && (wordCnt != LASTWORD)) wordCnt <= wordCnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
